pe_feeder: RTL and testbench
============================

Name: pe_feeder

Overview:
- Transmit side of the PE pixel/weight interface.
- Walks every valid KxK window of an image held in single-port image SRAM, in raster order.
- For each window, emits K*K back-to-back (pixel, weight) pairs with no gaps, because the PE accumulator free-runs over exactly K*K taps.
- Weights sit in an internal register file loaded before start; windows are streamed back-to-back until the image is exhausted.

Parameters:
- knl_size, 5, kernel edge K; taps per window = K*K.
- data_width, 16, pixel width.
- weight_width, 16, weight width.
- img_width, 32, image columns W (must be >= K).
- img_height, 32, image rows H (must be >= K).
- addr_width, 10, SRAM address width; must satisfy 2^addr_width >= W*H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final tap is emitted.
- w_wr_en  in  1  weight register write strobe.
- w_wr_addr  in  5  tap index 0..K*K-1, in raster order ky*K+kx.
- w_wr_dat  in  weight_width  weight value.
- mem_rd_en  out  1  SRAM read request.
- mem_rd_addr  out  addr_width  SRAM read address.
- mem_rd_dat  in  data_width  SRAM read data, valid the cycle after mem_rd_en.
- picDat  out  data_width  pixel to PE.
- weightDat  out  weight_width  weight to PE.
- pic_vld  out  1  picDat/weightDat valid.
- win_first  out  1  marks tap 0 of a window.
- win_last  out  1  marks tap K*K-1 of a window.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters cleared. Weight registers are also cleared to 0.
- Reset mid-run aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the read for the last tap of the last window is issued.
  - DRAIN -> DONE when that tap's output is registered.
  - DONE -> IDLE after one cycle, with done=1 in that cycle.
- busy=1 in RUN and DRAIN. start while busy is ignored.
- Read issue in RUN, one read per cycle, mem_rd_en held continuously (no bubbles):
  - Window (r,c) iterates r=0..H-K, then c=0..W-K inner; taps iterate ky=0..K-1, then kx=0..K-1 inner.
  - mem_rd_addr = (r+ky)*W + (c+kx).
  - Address is produced by incremental counters: +1 per kx, +W-K+1 at ky wrap, and a window base advance. No multiplier.
- Output pipeline:
  - The read issued in cycle n appears on picDat in cycle n+2 (SRAM latency plus output register).
  - In that same cycle, weightDat = weight[ky*K+kx] for that tap, using a delayed tap index.
  - pic_vld, win_first and win_last are delayed identically, so they are aligned with picDat.
- Output counts: pic_vld stays high for exactly (H-K+1)*(W-K+1)*K*K consecutive cycles. Defaults: 784 windows, 19600 taps.
- win_first and win_last each pulse once per window. They never assert together (K >= 2).
- Outputs hold at 0 whenever pic_vld=0.
- Weight writes:
  - Accepted only when busy=0. Ignored while busy, so weights are stable for the whole run.
  - w_wr_addr >= K*K is ignored.
  - A write coinciding with start is accepted, and the start is also accepted.
- Timing: the first pic_vld occurs 3 cycles after the start cycle. done occurs 1 cycle after the last pic_vld.
- Arithmetic: all counters are unsigned, sized by clog2 of their ranges. No wrap-around is permitted within a run.

Decomposition:
- Shared package pe_pkg:
  - FSM state enum.
  - TAPS = knl_size*knl_size.
  - Localparams for window counts.
  - Tap-index width function (clog2).
- One sub-module, pe_win_addr_gen:
  - Holds the r/c/ky/kx counters.
  - Produces mem_rd_addr, the tap index, first/last flags and the end-of-image flag.
- The top level holds the weight registers, the 2-stage output pipeline and the FSM.

Test Plan (bench parameters W=H=6, K=5, SRAM word[a]=a, weight[i]=100+i):
- Start after loading weights -> 4 windows, 100 consecutive pic_vld cycles.
  - Window 0 picDat sequence is 0,1,2,3,4,6,...,28; weightDat is 100..124.
  - win_first on the cycles picDat=0,1,6,7; win_last on the cycles picDat=28,29,34,35.
- Latency check: start at cycle 10 -> first mem_rd_en at cycle 11 (addr 0), first pic_vld at cycle 13.
  - Last pic_vld at cycle 112 (picDat=35); done=1 only at cycle 113; busy low at cycle 114.
- Weight write to tap 7 with value 0xBEEF while busy -> ignored; weightDat stays 107 at tap 7 of every window.
  - Same write after done -> the next run shows 0xBEEF at tap 7.
- start pulsed again mid-run -> no restart. Tap count stays 100; exactly one done pulse.
- rst asserted at tap 40 of the run -> next cycle all outputs 0, state IDLE, weights 0, no done.
  - A subsequent start yields a full 100-tap run with weightDat=0.
- Default params (32x32) -> 19600 pic_vld cycles with no gaps; last picDat=1023; 784 win_last pulses.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types, default geometry and width helpers for the PE feeder.
package pe_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_state_t;

    localparam int KNL_SIZE    = 5;
    localparam int IMG_WIDTH   = 32;
    localparam int IMG_HEIGHT  = 32;
    localparam int TAPS        = KNL_SIZE * KNL_SIZE;
    localparam int WIN_COLS    = IMG_WIDTH - KNL_SIZE + 1;
    localparam int WIN_ROWS    = IMG_HEIGHT - KNL_SIZE + 1;
    localparam int NUM_WINDOWS = WIN_COLS * WIN_ROWS;

    // A counter spanning 0..range-1 never gets narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range <= 2) ? 1 : $clog2(range);
    endfunction

    function automatic int tap_width(input int k);
        return cnt_width(k * k);
    endfunction

endpackage

// File: rtl/pe_win_addr_gen.sv
// Raster walk over every KxK window; produces the SRAM address and tap bookkeeping
// incrementally, so no multiplier is needed.
module pe_win_addr_gen import pe_pkg::*; #(
    parameter int knl_size   = KNL_SIZE,
    parameter int img_width  = IMG_WIDTH,
    parameter int img_height = IMG_HEIGHT,
    parameter int addr_width = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            adv,
    output logic [addr_width-1:0]           addr,
    output logic [tap_width(knl_size)-1:0]  tap,
    output logic                            first,
    output logic                            last,
    output logic                            end_img
);

    localparam int KW = cnt_width(knl_size);
    localparam int RW = cnt_width(img_height - knl_size + 1);
    localparam int CW = cnt_width(img_width - knl_size + 1);

    localparam logic [KW-1:0]         K_MAX    = KW'(knl_size - 1);
    localparam logic [RW-1:0]         R_MAX    = RW'(img_height - knl_size);
    localparam logic [CW-1:0]         C_MAX    = CW'(img_width - knl_size);
    localparam logic [addr_width-1:0] ROW_SKIP = addr_width'(img_width - knl_size + 1);
    localparam logic [addr_width-1:0] ROW_ADV  = addr_width'(knl_size);

    logic [KW-1:0]         kx;
    logic [KW-1:0]         ky;
    logic [RW-1:0]         r;
    logic [CW-1:0]         c;
    logic [addr_width-1:0] base;
    logic                  kx_end;
    logic                  ky_end;
    logic                  c_end;
    logic                  r_end;

    assign kx_end  = (kx == K_MAX);
    assign ky_end  = (ky == K_MAX);
    assign c_end   = (c == C_MAX);
    assign r_end   = (r == R_MAX);
    assign first   = (tap == '0);
    assign last    = kx_end && ky_end;
    assign end_img = last && c_end && r_end;

    // base tracks the top-left pixel of the window; at the end of a window row
    // it jumps by K, landing on column 0 of the next row. The final wrap leaves
    // every counter at zero, ready for the next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            kx   <= '0;
            ky   <= '0;
            r    <= '0;
            c    <= '0;
            tap  <= '0;
            base <= '0;
            addr <= '0;
        end else if (adv) begin
            if (kx_end && ky_end) begin
                kx  <= '0;
                ky  <= '0;
                tap <= '0;
                if (!c_end) begin
                    c    <= c + 1'b1;
                    base <= base + 1'b1;
                    addr <= base + 1'b1;
                end else if (!r_end) begin
                    c    <= '0;
                    r    <= r + 1'b1;
                    base <= base + ROW_ADV;
                    addr <= base + ROW_ADV;
                end else begin
                    c    <= '0;
                    r    <= '0;
                    base <= '0;
                    addr <= '0;
                end
            end else if (kx_end) begin
                kx   <= '0;
                ky   <= ky + 1'b1;
                tap  <= tap + 1'b1;
                addr <= addr + ROW_SKIP;
            end else begin
                kx   <= kx + 1'b1;
                tap  <= tap + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Streams (pixel, weight) pairs for every KxK window of an SRAM-resident image
// to the PE, K*K taps per window with no gaps.
module pe_feeder import pe_pkg::*; #(
    parameter int knl_size     = KNL_SIZE,
    parameter int data_width   = 16,
    parameter int weight_width = 16,
    parameter int img_width    = IMG_WIDTH,
    parameter int img_height   = IMG_HEIGHT,
    parameter int addr_width   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    w_wr_en,
    input  logic [4:0]              w_wr_addr,
    input  logic [weight_width-1:0] w_wr_dat,
    output logic                    mem_rd_en,
    output logic [addr_width-1:0]   mem_rd_addr,
    input  logic [data_width-1:0]   mem_rd_dat,
    output logic [data_width-1:0]   picDat,
    output logic [weight_width-1:0] weightDat,
    output logic                    pic_vld,
    output logic                    win_first,
    output logic                    win_last
);

    localparam int         TAPS_N    = knl_size * knl_size;
    localparam int         TW        = tap_width(knl_size);
    localparam logic [4:0] TAP_LIMIT = 5'(TAPS_N);

    fsm_state_t              state;
    logic                    run;
    logic [addr_width-1:0]   gen_addr;
    logic [TW-1:0]           gen_tap;
    logic                    gen_first;
    logic                    gen_last;
    logic                    gen_end;
    logic                    vld1;
    logic                    first1;
    logic                    last1;
    logic [TW-1:0]           tap1;
    logic [weight_width-1:0] weights [TAPS_N];

    assign run         = (state == RUN);
    assign mem_rd_en   = run;
    assign mem_rd_addr = gen_addr;

    pe_win_addr_gen #(
        .knl_size   (knl_size),
        .img_width  (img_width),
        .img_height (img_height),
        .addr_width (addr_width)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .adv     (run),
        .addr    (gen_addr),
        .tap     (gen_tap),
        .first   (gen_first),
        .last    (gen_last),
        .end_img (gen_end)
    );

    // Weights only change while idle, so the whole run sees one coefficient set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS_N; i++) begin
                weights[i] <= '0;
            end
        end else if (w_wr_en && !busy && (w_wr_addr < TAP_LIMIT)) begin
            weights[w_wr_addr] <= w_wr_dat;
        end
    end

    // Stage 1 rides alongside the SRAM access; stage 2 lands data and weight together.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1      <= 1'b0;
            first1    <= 1'b0;
            last1     <= 1'b0;
            tap1      <= '0;
            pic_vld   <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            picDat    <= '0;
            weightDat <= '0;
        end else begin
            vld1      <= run;
            first1    <= run && gen_first;
            last1     <= run && gen_last;
            tap1      <= run ? gen_tap : '0;
            pic_vld   <= vld1;
            win_first <= first1;
            win_last  <= last1;
            picDat    <= vld1 ? mem_rd_dat : '0;
            weightDat <= vld1 ? weights[tap1] : '0;
        end
    end

    // DRAIN waits until the final tap has left stage 1, so done follows the last pic_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (gen_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!vld1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench: a small 6x6/K=5 instance against a window-walk model,
// plus a default 32x32 instance checked for stream length and continuity.
module tb_pe_feeder;

    localparam int K          = 5;
    localparam int W          = 6;
    localparam int H          = 6;
    localparam int DW         = 16;
    localparam int WW         = 16;
    localparam int AW         = 10;
    localparam int NCOL       = W - K + 1;
    localparam int NROW       = H - K + 1;
    localparam int TAPS       = K * K;
    localparam int TOTAL      = NCOL * NROW * TAPS;
    localparam int BIG_WIN    = 28 * 28;
    localparam int BIG_TOTAL  = BIG_WIN * 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          w_wr_en;
    logic [4:0]    w_wr_addr;
    logic [WW-1:0] w_wr_dat;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_dat;
    logic [DW-1:0] picDat;
    logic [WW-1:0] weightDat;
    logic          pic_vld;
    logic          win_first;
    logic          win_last;

    logic          b_start;
    logic          b_busy;
    logic          b_done;
    logic          b_mem_rd_en;
    logic [AW-1:0] b_mem_rd_addr;
    logic [DW-1:0] b_mem_rd_dat;
    logic [DW-1:0] b_picDat;
    logic [WW-1:0] b_weightDat;
    logic          b_pic_vld;
    logic          b_win_first;
    logic          b_win_last;

    pe_feeder #(
        .knl_size(K), .data_width(DW), .weight_width(WW),
        .img_width(W), .img_height(H), .addr_width(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_dat(w_wr_dat),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_dat(mem_rd_dat),
        .picDat(picDat), .weightDat(weightDat), .pic_vld(pic_vld),
        .win_first(win_first), .win_last(win_last)
    );

    pe_feeder dut_big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .w_wr_en(1'b0), .w_wr_addr(5'd0), .w_wr_dat(16'd0),
        .mem_rd_en(b_mem_rd_en), .mem_rd_addr(b_mem_rd_addr), .mem_rd_dat(b_mem_rd_dat),
        .picDat(b_picDat), .weightDat(b_weightDat), .pic_vld(b_pic_vld),
        .win_first(b_win_first), .win_last(b_win_last)
    );

    // SRAM images hold word[a] = a, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en)   mem_rd_dat   <= DW'(mem_rd_addr);
        if (b_mem_rd_en) b_mem_rd_dat <= DW'(b_mem_rd_addr);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model: tracks the accepted start cycle and the weight file from the input side only.
    int            cyc      = 0;
    bit            m_active = 1'b0;
    int            m_s      = 0;
    logic [WW-1:0] m_w [TAPS];

    function automatic bit in_busy(input int c);
        return m_active && (c >= m_s + 1) && (c <= m_s + TOTAL + 2);
    endfunction

    function automatic bit in_idle(input int c);
        return !m_active || (c >= m_s + TOTAL + 4);
    endfunction

    function automatic int tap_pix(input int k);
        int w, t, r, c, ky, kx;
        w  = k / TAPS;
        t  = k % TAPS;
        r  = w / NCOL;
        c  = w % NCOL;
        ky = t / K;
        kx = t % K;
        return (r + ky) * W + c + kx;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            foreach (m_w[i]) m_w[i] = '0;
        end else begin
            if (w_wr_en && !in_busy(cyc) && (w_wr_addr < TAPS)) m_w[w_wr_addr] = w_wr_dat;
            if (start && in_idle(cyc)) begin
                m_active = 1'b1;
                m_s      = cyc;
            end
        end
        cyc++;
    end

    int       cmp_k;
    int       cmp_rk;
    bit       cmp_ev;
    bit       cmp_er;
    int       vld_cnt  = 0;
    int       done_cnt = 0;
    int       first_q[$];
    int       last_q[$];

    always @(negedge clk) begin
        if (cyc >= 2) begin
            cmp_k  = cyc - m_s - 3;
            cmp_rk = cyc - m_s - 1;
            cmp_ev = m_active && (cmp_k >= 0) && (cmp_k < TOTAL);
            cmp_er = m_active && (cmp_rk >= 0) && (cmp_rk < TOTAL);
            checkOutput("pic_vld", pic_vld, cmp_ev);
            checkOutput("win_first", win_first, cmp_ev && (cmp_k % TAPS == 0));
            checkOutput("win_last", win_last, cmp_ev && (cmp_k % TAPS == TAPS - 1));
            if (cmp_ev) begin
                checkOutput("picDat", picDat, tap_pix(cmp_k));
                checkOutput("weightDat", weightDat, m_w[cmp_k % TAPS]);
            end else begin
                checkOutput("picDat_idle", picDat, 0);
                checkOutput("weightDat_idle", weightDat, 0);
            end
            checkOutput("busy", busy, in_busy(cyc));
            checkOutput("done", done, m_active && (cyc == m_s + TOTAL + 3));
            checkOutput("mem_rd_en", mem_rd_en, cmp_er);
            if (cmp_er) checkOutput("mem_rd_addr", mem_rd_addr, tap_pix(cmp_rk));
            if (pic_vld) vld_cnt++;
            if (pic_vld && win_first) first_q.push_back(int'(picDat));
            if (pic_vld && win_last) last_q.push_back(int'(picDat));
            if (done) done_cnt++;
        end
    end

    int b_cnt = 0, b_wl = 0, b_wf = 0, b_last = 0, b_gaps = 0, b_done_cnt = 0;
    bit b_prev = 1'b0;

    always @(negedge clk) begin
        if (b_pic_vld) begin
            b_cnt++;
            b_last = int'(b_picDat);
            if (b_win_last)  b_wl++;
            if (b_win_first) b_wf++;
        end
        if (b_prev && !b_pic_vld && (b_cnt < BIG_TOTAL)) b_gaps++;
        if (b_done) b_done_cnt++;
        b_prev = b_pic_vld;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic applyStimulus(input bit st, input bit we, input logic [4:0] a, input logic [WW-1:0] d);
        start     = st;
        w_wr_en   = we;
        w_wr_addr = a;
        w_wr_dat  = d;
        tick();
        start     = 1'b0;
        w_wr_en   = 1'b0;
    endtask

    task automatic clear_monitors();
        vld_cnt  = 0;
        done_cnt = 0;
        first_q.delete();
        last_q.delete();
    endtask

    int s;
    int exp_first[4] = '{0, 1, 6, 7};
    int exp_last[4]  = '{28, 29, 34, 35};

    initial begin
        rst = 1'b1; start = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_dat = '0; b_start = 1'b0;
        wait_until(3);
        checkOutput("reset_pic_vld", pic_vld, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_mem_rd_en", mem_rd_en, 0);
        rst = 1'b0;
        for (int i = 0; i < TAPS; i++) applyStimulus(1'b0, 1'b1, 5'(i), WW'(100 + i));

        $display("[TB] run 1: baseline and latency");
        clear_monitors();
        s = cyc;
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("lat_rd_en", mem_rd_en, 1);
        checkOutput("lat_rd_addr", mem_rd_addr, 0);
        checkOutput("lat_busy", busy, 1);
        wait_until(s + 2);
        checkOutput("lat_no_vld", pic_vld, 0);
        wait_until(s + 3);
        checkOutput("lat_vld", pic_vld, 1);
        checkOutput("tap0_pix", picDat, 0);
        checkOutput("tap0_wt", weightDat, 100);
        checkOutput("tap0_first", win_first, 1);
        wait_until(s + 8);
        checkOutput("tap5_pix", picDat, 6);
        checkOutput("tap5_wt", weightDat, 105);
        wait_until(s + 27);
        checkOutput("tap24_pix", picDat, 28);
        checkOutput("tap24_wt", weightDat, 124);
        checkOutput("tap24_last", win_last, 1);
        wait_until(s + 102);
        checkOutput("final_vld", pic_vld, 1);
        checkOutput("final_pix", picDat, 35);
        wait_until(s + 103);
        checkOutput("done_pulse", done, 1);
        checkOutput("done_vld_low", pic_vld, 0);
        wait_until(s + 104);
        checkOutput("busy_low", busy, 0);
        checkOutput("done_once", done, 0);
        checkOutput("run1_taps", vld_cnt, 100);
        checkOutput("run1_dones", done_cnt, 1);
        checkOutput("first_count", first_q.size(), 4);
        checkOutput("last_count", last_q.size(), 4);
        for (int i = 0; i < 4 && i < first_q.size(); i++) checkOutput("first_pix", first_q[i], exp_first[i]);
        for (int i = 0; i < 4 && i < last_q.size(); i++) checkOutput("last_pix", last_q[i], exp_last[i]);

        $display("[TB] run 2: writes and start ignored while busy");
        clear_monitors();
        s = cyc;
        applyStimulus(1'b1, 1'b0, '0, '0);
        wait_until(s + 20);
        applyStimulus(1'b0, 1'b1, 5'd7, 16'hBEEF);
        wait_until(s + 35);
        checkOutput("busy_wr_pix", picDat, 9);
        checkOutput("busy_wr_wt", weightDat, 107);
        wait_until(s + 50);
        applyStimulus(1'b1, 1'b0, '0, '0);
        wait_until(s + 110);
        checkOutput("run2_taps", vld_cnt, 100);
        checkOutput("run2_dones", done_cnt, 1);

        $display("[TB] run 3: write after done");
        applyStimulus(1'b0, 1'b1, 5'd7, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 5'd25, 16'hDEAD);
        applyStimulus(1'b0, 1'b1, 5'd31, 16'hDEAD);
        clear_monitors();
        s = cyc;
        applyStimulus(1'b1, 1'b0, '0, '0);
        wait_until(s + 10);
        checkOutput("new_wt_tap7", weightDat, 16'hBEEF);
        wait_until(s + 85);
        checkOutput("new_wt_win3", weightDat, 16'hBEEF);
        wait_until(s + 110);
        checkOutput("run3_taps", vld_cnt, 100);
        checkOutput("run3_dones", done_cnt, 1);

        $display("[TB] run 4: reset mid-run");
        clear_monitors();
        s = cyc;
        applyStimulus(1'b1, 1'b0, '0, '0);
        wait_until(s + 43);
        checkOutput("pre_rst_pix", picDat, tap_pix(40));
        rst = 1'b1;
        tick();
        checkOutput("rst_vld", pic_vld, 0);
        checkOutput("rst_pix", picDat, 0);
        checkOutput("rst_wt", weightDat, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rd_en", mem_rd_en, 0);
        checkOutput("rst_first", win_first, 0);
        checkOutput("rst_last", win_last, 0);
        rst = 1'b0;
        wait_until(s + 120);
        checkOutput("abort_taps", vld_cnt, 41);
        checkOutput("abort_dones", done_cnt, 0);

        $display("[TB] run 5: start with coincident write after reset");
        clear_monitors();
        s = cyc;
        applyStimulus(1'b1, 1'b1, 5'd3, 16'h1234);
        wait_until(s + 6);
        checkOutput("coinc_wt", weightDat, 16'h1234);
        wait_until(s + 10);
        checkOutput("cleared_wt", weightDat, 0);
        wait_until(s + 110);
        checkOutput("run5_taps", vld_cnt, 100);
        checkOutput("run5_dones", done_cnt, 1);

        $display("[TB] default 32x32 instance");
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < BIG_TOTAL + 100 && b_done_cnt == 0; i++) tick();
        tick();
        checkOutput("big_done", b_done_cnt, 1);
        checkOutput("big_taps", b_cnt, BIG_TOTAL);
        checkOutput("big_gaps", b_gaps, 0);
        checkOutput("big_win_last", b_wl, BIG_WIN);
        checkOutput("big_win_first", b_wf, BIG_WIN);
        checkOutput("big_last_pix", b_last, 1023);
        checkOutput("big_busy_low", b_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
